// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync + FILT-cycle stability filter + Gray-code step decode into a wrapping position.
// Latency 1+FILT edges after the first sampling edge of a new A/B level; no backpressure, step is a 1-cycle pulse.
module quad_decoder #(
  parameter int WIDTH = 16,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] position,
  output logic             dir,
  output logic             step,
  output logic             err
);

  typedef enum logic {INIT, TRACK} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync1, ab_s, ab_prev, ab_f, ab_f_nxt;
  logic [1:0]       vld_sr;
  logic [3:0]       cnt, cnt_nxt;
  logic             stable;
  logic             is_up, is_down;
  logic [WIDTH-1:0] pos_nxt;
  logic             dir_nxt, step_nxt, err_nxt;

  // Successor of a phase pair in the counting-up direction.
  function automatic logic [1:0] up_of(input logic [1:0] v);
    case (v)
      2'b00:   up_of = 2'b01;
      2'b01:   up_of = 2'b11;
      2'b11:   up_of = 2'b10;
      default: up_of = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 2'b00;
      ab_s    <= 2'b00;
      vld_sr  <= 2'b00;
      ab_prev <= 2'b00;
      cnt     <= 4'd0;
    end else begin
      sync1   <= {a_in, b_in};
      ab_s    <= sync1;
      vld_sr  <= {vld_sr[0], 1'b1};
      ab_prev <= ab_s;
      cnt     <= cnt_nxt;
    end
  end

  // vld_sr keeps the reset-zero contents of the synchroniser from being accepted as a real level.
  always_comb begin
    cnt_nxt = 4'd0;
    if (ab_s == ab_prev)
      cnt_nxt = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
    stable = vld_sr[1] && (cnt_nxt >= 4'(FILT - 1));
  end

  assign is_up   = (ab_s == up_of(ab_f));
  assign is_down = (ab_f == up_of(ab_s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      ab_f     <= 2'b00;
      position <= '0;
      dir      <= 1'b1;
      step     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ab_f     <= ab_f_nxt;
      position <= pos_nxt;
      dir      <= dir_nxt;
      step     <= step_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ab_f_nxt  = ab_f;
    pos_nxt   = position;
    dir_nxt   = dir;
    step_nxt  = 1'b0;
    err_nxt   = err_clr ? 1'b0 : err;
    case (state)
      INIT: begin
        if (stable) begin
          ab_f_nxt  = ab_s;
          state_nxt = TRACK;
        end
      end
      default: begin
        if (stable && (ab_s != ab_f)) begin
          ab_f_nxt = ab_s;
          if (is_up) begin
            dir_nxt = 1'b1;
            if (en) begin
              pos_nxt  = position + 1'b1;
              step_nxt = 1'b1;
            end
          end else if (is_down) begin
            dir_nxt = 1'b0;
            if (en) begin
              pos_nxt  = position - 1'b1;
              step_nxt = 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
    endcase
    if (clr)
      pos_nxt = '0;
  end

endmodule
